// File: rtl/mlp_pkg.sv
// Shared MLP datapath definitions: layer FSM state type, width legality check
// and the width-generic ReLU/saturate helper.
package mlp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        POST  = 2'd3
    } fc_state_t;

    // Widest intermediate the saturate helper handles; lanes sign-extend into it.
    localparam int unsigned SAT_W = 48;

    function automatic bit acc_width_ok(input int unsigned dw, input int unsigned n,
                                        input int unsigned aw);
        return (aw >= 2 * dw + $clog2(n)) && (aw < SAT_W);
    endfunction

    function automatic logic signed [SAT_W-1:0] relu_sat(input logic signed [SAT_W-1:0] v,
                                                         input int unsigned dw,
                                                         input bit relu);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] r;
        hi = (48'sd1 <<< (dw - 1)) - 48'sd1;
        lo = -(48'sd1 <<< (dw - 1));
        r  = v;
        if (relu && r < 0) r = '0;
        if (r > hi)      r = hi;
        else if (r < lo) r = lo;
        return r;
    endfunction

endpackage

// File: rtl/fc_layer_seq_if.sv
// Handshake, weight-read and data bus of one fully-connected layer.
interface fc_layer_seq_if #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned INPUT_NODES  = 24,
    parameter int unsigned OUTPUT_NODES = 128,
    parameter int unsigned ADDR_WIDTH   = $clog2(INPUT_NODES)
);
    logic                               start;
    logic                               busy;
    logic                               done;
    logic [DATA_WIDTH*INPUT_NODES-1:0]  input_fc;
    logic [DATA_WIDTH*OUTPUT_NODES-1:0] bias;
    logic                               weight_rd_en;
    logic [ADDR_WIDTH-1:0]              weight_addr;
    logic [DATA_WIDTH*OUTPUT_NODES-1:0] weights;
    logic [DATA_WIDTH*OUTPUT_NODES-1:0] output_fc;

    modport slave (
        input  start, input_fc, bias, weights,
        output busy, done, weight_rd_en, weight_addr, output_fc
    );

    modport master (
        output start, input_fc, bias, weights,
        input  busy, done, weight_rd_en, weight_addr, output_fc
    );
endinterface

// File: rtl/fc_layer_seq_mac_lane.sv
// One output lane: signed MAC with clear/enable, then bias, arithmetic shift,
// optional ReLU and saturation into a registered result.
module mac_lane
    import mlp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 24,
    parameter int unsigned OUT_SHIFT  = 0,
    parameter bit          RELU       = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clr,
    input  logic                         en,
    input  logic                         post,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    input  logic signed [DATA_WIDTH-1:0] bias,
    output logic signed [DATA_WIDTH-1:0] result
);
    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH:0]      biased;
    logic signed [ACC_WIDTH:0]      shifted;

    always_comb begin
        prod    = a * b;
        biased  = (ACC_WIDTH + 1)'(acc) + (ACC_WIDTH + 1)'(bias);
        shifted = biased >>> OUT_SHIFT;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc    <= '0;
            result <= '0;
        end else begin
            if (clr)     acc <= '0;
            else if (en) acc <= acc + ACC_WIDTH'(prod);
            if (post) result <= DATA_WIDTH'(relu_sat(SAT_W'(shifted), DATA_WIDTH, RELU));
        end
    end
endmodule

// File: rtl/fc_layer_seq.sv
// Self-sequencing fully-connected layer: snapshots the input vector, walks the
// weight rows one per cycle and feeds OUTPUT_NODES parallel MAC lanes.
module fc_layer_seq
    import mlp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned INPUT_NODES  = 24,
    parameter int unsigned OUTPUT_NODES = 128,
    parameter int unsigned ACC_WIDTH    = 24,
    parameter int unsigned OUT_SHIFT    = 0,
    parameter int unsigned RELU         = 1,
    parameter int unsigned ADDR_WIDTH   = $clog2(INPUT_NODES)
) (
    input logic          clk,
    input logic          reset,
    fc_layer_seq_if.slave bus
);
    if (!acc_width_ok(DATA_WIDTH, INPUT_NODES, ACC_WIDTH)) begin : g_acc_chk
        $error("fc_layer_seq: ACC_WIDTH too small for DATA_WIDTH/INPUT_NODES");
    end

    fc_state_t                   state;
    logic signed [DATA_WIDTH-1:0] snap [INPUT_NODES];
    logic signed [DATA_WIDTH-1:0] in_pipe;
    logic                         en_pipe;
    logic                         busy_r;
    logic                         done_r;
    logic                         rd_en_r;
    logic [ADDR_WIDTH-1:0]        k;
    logic [OUTPUT_NODES-1:0][DATA_WIDTH-1:0] lane_res;
    logic                         clr;
    logic                         post;
    logic                         last;

    assign clr  = (state == IDLE) && bus.start;
    assign post = (state == POST);
    assign last = (k == ADDR_WIDTH'(INPUT_NODES - 1));

    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.weight_rd_en = rd_en_r;
    assign bus.weight_addr  = k;
    assign bus.output_fc    = lane_res;

    // in_pipe/en_pipe lag the address by one cycle to line up with the weight data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            k       <= '0;
            rd_en_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            in_pipe <= '0;
            en_pipe <= 1'b0;
            for (int unsigned i = 0; i < INPUT_NODES; i++) snap[i] <= '0;
        end else begin
            en_pipe <= (state == RUN);
            done_r  <= 1'b0;
            case (state)
                IDLE: begin
                    busy_r <= bus.start;
                    if (bus.start) begin
                        state   <= RUN;
                        k       <= '0;
                        rd_en_r <= 1'b1;
                        for (int unsigned i = 0; i < INPUT_NODES; i++)
                            snap[i] <= bus.input_fc[DATA_WIDTH*i +: DATA_WIDTH];
                    end
                end
                RUN: begin
                    in_pipe <= snap[k];
                    if (last) begin
                        state   <= DRAIN;
                        rd_en_r <= 1'b0;
                        k       <= '0;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DRAIN: state <= POST;
                POST: begin
                    done_r <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < OUTPUT_NODES; g++) begin : g_lane
        mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .OUT_SHIFT  (OUT_SHIFT),
            .RELU       (RELU != 0)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .clr    (clr),
            .en     (en_pipe),
            .post   (post),
            .a      (in_pipe),
            .b      (bus.weights[DATA_WIDTH*g +: DATA_WIDTH]),
            .bias   (bus.bias[DATA_WIDTH*g +: DATA_WIDTH]),
            .result (lane_res[g])
        );
    end
endmodule

// File: tb/tb_fc_layer_seq.sv
// Directed bench for fc_layer_seq: three small instances (ReLU, linear, shift-by-2)
// share stimulus and a 1-cycle-latency weight model.
module tb_fc_layer_seq;
    localparam int DW = 8;
    localparam int NI = 4;
    localparam int NO = 2;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic [DW*NI-1:0] input_fc;
    logic [DW*NO-1:0] bias;
    logic [DW-1:0]    wmem [NI][NO];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fc_layer_seq_if #(.DATA_WIDTH(DW), .INPUT_NODES(NI), .OUTPUT_NODES(NO), .ADDR_WIDTH(AW))
        if_a(), if_b(), if_c();

    fc_layer_seq #(.DATA_WIDTH(DW), .INPUT_NODES(NI), .OUTPUT_NODES(NO), .ACC_WIDTH(24),
                   .OUT_SHIFT(0), .RELU(1), .ADDR_WIDTH(AW))
        dut_a (.clk(clk), .reset(reset), .bus(if_a));
    fc_layer_seq #(.DATA_WIDTH(DW), .INPUT_NODES(NI), .OUTPUT_NODES(NO), .ACC_WIDTH(24),
                   .OUT_SHIFT(0), .RELU(0), .ADDR_WIDTH(AW))
        dut_b (.clk(clk), .reset(reset), .bus(if_b));
    fc_layer_seq #(.DATA_WIDTH(DW), .INPUT_NODES(NI), .OUTPUT_NODES(NO), .ACC_WIDTH(24),
                   .OUT_SHIFT(2), .RELU(0), .ADDR_WIDTH(AW))
        dut_c (.clk(clk), .reset(reset), .bus(if_c));

    assign if_a.start = start;  assign if_a.input_fc = input_fc;  assign if_a.bias = bias;
    assign if_b.start = start;  assign if_b.input_fc = input_fc;  assign if_b.bias = bias;
    assign if_c.start = start;  assign if_c.input_fc = input_fc;  assign if_c.bias = bias;

    function automatic logic [DW*NO-1:0] row(input logic [AW-1:0] k);
        logic [DW*NO-1:0] r;
        for (int l = 0; l < NO; l++) r[DW*l +: DW] = wmem[k][l];
        return r;
    endfunction

    always @(posedge clk) begin
        if_a.weights <= row(if_a.weight_addr);
        if_b.weights <= row(if_b.weight_addr);
        if_c.weights <= row(if_c.weight_addr);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input int x0, input int x1, input int x2, input int x3);
        input_fc = {8'(x3), 8'(x2), 8'(x1), 8'(x0)};
    endtask

    task automatic set_w(input int lane, input int w0, input int w1, input int w2, input int w3);
        wmem[0][lane] = 8'(w0);
        wmem[1][lane] = 8'(w1);
        wmem[2][lane] = 8'(w2);
        wmem[3][lane] = 8'(w3);
    endtask

    task automatic set_bias(input int b0, input int b1);
        bias = {8'(b1), 8'(b0)};
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (if_a.done) begin
                cycles = c;
                break;
            end
        end
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            if (if_a.done) cnt++;
        end
    endtask

    // One pass; poke re-asserts start and scrambles input_fc while busy.
    task automatic run_pass(input string tag, input logic [15:0] ea, input logic [15:0] eb,
                            input logic [15:0] ec, input bit poke);
        int rd_cnt;
        int lat;
        int extra;
        rd_cnt = 0;
        lat    = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check_val({tag, " busy_rise"}, 32'(if_a.busy), 32'd1);
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            if (if_a.weight_rd_en) begin
                check_val({tag, " addr"}, 32'(if_a.weight_addr), 32'(rd_cnt));
                rd_cnt++;
            end
            if (poke && c == 2) begin
                start    = 1'b1;
                input_fc = 32'h7F7F7F7F;
            end
            if (poke && c == 3) start = 1'b0;
            @(posedge clk); #1;
            if (if_a.done) lat = c;
        end
        check_val({tag, " latency"}, 32'(lat), 32'd6);
        check_val({tag, " rd_en_cycles"}, 32'(rd_cnt), 32'd4);
        check_val({tag, " done_bc"}, {30'd0, if_b.done, if_c.done}, 32'd3);
        check_val({tag, " busy_at_done"}, 32'(if_a.busy), 32'd1);
        check_val({tag, " out_a"}, 32'(if_a.output_fc), 32'(ea));
        check_val({tag, " out_b"}, 32'(if_b.output_fc), 32'(eb));
        check_val({tag, " out_c"}, 32'(if_c.output_fc), 32'(ec));
        count_done(8, extra);
        check_val({tag, " extra_done"}, 32'(extra), 32'd0);
        check_val({tag, " busy_after"}, 32'(if_a.busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1;
        int gap;
        int cnt;
        reset = 1'b0;
        start = 1'b0;
        input_fc = '0;
        bias = '0;
        for (int k = 0; k < NI; k++) for (int l = 0; l < NO; l++) wmem[k][l] = '0;
        #12;
        check_val("reset out", 32'(if_a.output_fc), 32'd0);
        check_val("reset ctl", {28'd0, if_a.done, if_a.busy, if_a.weight_rd_en, 1'b0}, 32'd0);
        check_val("reset addr", 32'(if_a.weight_addr), 32'd0);
        @(negedge clk); reset = 1'b1;

        // Basic dot product: acc = {10, -2}
        set_in(1, 2, 3, 4); set_w(0, 1, 1, 1, 1); set_w(1, 1, -1, 1, -1); set_bias(0, 0);
        run_pass("basic", 16'h000A, 16'hFE0A, 16'hFF02, 1'b0);

        // Positive saturation: acc = 64516
        set_in(127, 127, 127, 127); set_w(0, 127, 127, 127, 127); set_w(1, 127, 127, 127, 127);
        run_pass("sat_pos", 16'h7F7F, 16'h7F7F, 16'h7F7F, 1'b0);

        // Negative saturation: acc = -65024
        set_w(0, -128, -128, -128, -128); set_w(1, -128, -128, -128, -128);
        run_pass("sat_neg", 16'h0000, 16'h8080, 16'h8080, 1'b0);

        // Bias and shift: lane0 10+6=16, lane1 -9
        set_in(1, 2, 3, 4); set_w(0, 1, 1, 1, 1); set_w(1, -1, 0, 0, -2); set_bias(6, 0);
        run_pass("bias_shift", 16'h0010, 16'hF710, 16'hFD04, 1'b0);

        // Start while busy plus input change after the start edge
        set_in(1, 2, 3, 4); set_w(0, 1, 1, 1, 1); set_w(1, 1, -1, 1, -1); set_bias(0, 0);
        run_pass("snapshot", 16'h000A, 16'hFE0A, 16'hFF02, 1'b1);

        // Start held high: back-to-back passes
        set_in(4, 3, 2, 1); set_w(0, 1, 1, 1, 1); set_w(1, 2, 0, 0, 0);
        @(negedge clk); start = 1'b1;
        wait_done(c1);
        wait_done(gap);
        start = 1'b0;
        check_val("b2b first", 32'(c1), 32'd7);
        check_val("b2b gap", 32'(gap), 32'd7);
        check_val("b2b out_a", 32'(if_a.output_fc), 32'h080A);
        count_done(10, cnt);
        check_val("b2b extra_done", 32'(cnt), 32'd0);

        // Reset mid-RUN at addr 2
        set_in(127, 127, 127, 127); set_w(0, 127, 127, 127, 127); set_w(1, 127, 127, 127, 127);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 10 && !(if_a.weight_rd_en && if_a.weight_addr == 2'd2); c++) begin
            @(posedge clk); #1;
        end
        check_val("rst addr2", 32'(if_a.weight_addr), 32'd2);
        reset = 1'b0;
        #1;
        check_val("rst out_a", 32'(if_a.output_fc), 32'd0);
        check_val("rst out_b", 32'(if_b.output_fc), 32'd0);
        check_val("rst out_c", 32'(if_c.output_fc), 32'd0);
        check_val("rst ctl", {28'd0, if_a.done, if_a.busy, if_a.weight_rd_en, 1'b0}, 32'd0);
        check_val("rst addr", 32'(if_a.weight_addr), 32'd0);
        @(negedge clk); @(negedge clk); reset = 1'b1;
        count_done(10, cnt);
        check_val("rst no_done", 32'(cnt), 32'd0);
        set_in(1, 2, 3, 4); set_w(0, 1, 1, 1, 1); set_w(1, 1, -1, 1, -1); set_bias(0, 0);
        run_pass("fresh", 16'h000A, 16'hFE0A, 16'hFF02, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
